instr_issue: RTL and testbench
==============================

INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2) SHALL be a parameter.
REQ-002 TIMEOUT_CYCLES, 15, max WAIT cycles before abort SHALL be a parameter.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 load_valid  in  1  instruction offered; load_instr  in  16  instruction word.
REQ-006 load_ready  out  1  buffer can accept.
REQ-007 a, b  out  8 each  operands to execute unit; opcode  out  3  operation.
REQ-008 issue_valid  out  1  a/b/opcode valid this cycle.
REQ-009 result_valid  in  1; result_in  in  8; carry_in  in  1  execute-unit response.
REQ-010 carry_flag  out  1  carry of last retired instruction.
REQ-011 busy  out  1  FSM not IDLE or buffer non-empty; retired  out  8  retired-instruction count.
REQ-012 dbg_addr  in  2; dbg_data  out  8  combinational register-file read.
REQ-013 timeout_err, spurious_err  out  1 each  sticky error flags.

Function
REQ-014 Instruction fields SHALL be [15:13] opcode, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm.
REQ-015 Register file SHALL be 4 x 8 bits.
REQ-016 Load SHALL be accepted on load_valid && load_ready; load_ready = !full (registered occupancy); load_valid while full is ignored.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-018 IDLE: if buffer non-empty, pop head into an instruction register and go to ISSUE next cycle; if empty, stay.
REQ-019 ISSUE: issue_valid=1 for exactly one cycle; a=reg[rd]; b = imm_sel ? imm : reg[rs]; opcode forwarded unmodified; go to WAIT.
REQ-020 a/b/opcode SHALL hold their values from ISSUE until the next ISSUE.
REQ-021 WAIT: on result_valid, write result_in to reg[rd], set carry_flag=carry_in, increment retired (mod 256), go to IDLE.
REQ-022 Minimum throughput SHALL be one instruction per 3 cycles (IDLE, ISSUE, WAIT with result_valid on the first WAIT cycle).
REQ-023 result_valid in IDLE or ISSUE SHALL set spurious_err; it SHALL cause no writeback.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 Writeback SHALL complete before the next ISSUE, so back-to-back dependent instructions read the updated register.

Reset
REQ-026 rst SHALL asynchronously clear: FSM to IDLE, FIFO empty, registers 0, a/b/opcode 0, issue_valid 0, carry_flag 0, retired 0, both error flags 0; load_ready=1 after reset.
REQ-027 rst during WAIT SHALL abandon the instruction without writeback.

Configuration
REQ-028 With ISSUE_TIMEOUT_EN defined, a WAIT counter SHALL abort after TIMEOUT_CYCLES cycles without result_valid: set timeout_err, no writeback, retired unchanged, return to IDLE.
REQ-029 Without ISSUE_TIMEOUT_EN, WAIT SHALL persist indefinitely and timeout_err SHALL be tied 0.

Structure
REQ-030 Package cpu8_pkg SHALL hold opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, SHL=110, PASS=111), instruction field positions and the FSM state type.
REQ-031 The buffer SHALL be a sub-module instr_fifo (parameterised depth, 16-bit data, full/empty outputs).

Verification
REQ-032 Load ADD r0,imm 5 then ADD r0,imm 3; responder returns a+b next cycle -> issues (a=0,b=5), (a=5,b=3); dbg r0=8; retired=2; carry_flag=0.
REQ-033 Load ADD r1,imm 0xCC then AND r1,imm 0xAA -> second issue a=0xCC, b=0xAA, opcode=010; r1=0x88.
REQ-034 Hold result_valid low, push 5 instructions with FIFO_DEPTH=4 -> load_ready low after the buffer is full; the 5th word is not accepted; all accepted words retire in order once results resume.
REQ-035 With ISSUE_TIMEOUT_EN, withhold result 15 cycles -> timeout_err=1, no writeback, next instruction issues.
REQ-036 Pulse result_valid in IDLE -> spurious_err=1, registers unchanged.
REQ-037 Assert rst mid-WAIT -> all outputs at reset values on the same edge, no writeback.

Source files
------------

// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit issue slice: opcode encodings,
// instruction field positions, the decoded instruction view and the
// issue FSM state type.
package cpu8_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int INSTR_W     = 16;
    localparam int OPC_MSB     = 15;
    localparam int OPC_LSB     = 13;
    localparam int RD_MSB      = 12;
    localparam int RD_LSB      = 11;
    localparam int RS_MSB      = 10;
    localparam int RS_LSB      = 9;
    localparam int IMM_SEL_BIT = 8;
    localparam int IMM_MSB     = 7;
    localparam int IMM_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       imm_sel;
        logic [7:0] imm;
    } instr_t;

    // Split a raw instruction word into its named fields.
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] word);
        instr_t d;
        d.opcode  = word[OPC_MSB:OPC_LSB];
        d.rd      = word[RD_MSB:RD_LSB];
        d.rs      = word[RS_MSB:RS_LSB];
        d.imm_sel = word[IMM_SEL_BIT];
        d.imm     = word[IMM_MSB:IMM_LSB];
        return d;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction buffer: power-of-two depth circular FIFO with an explicit
// occupancy counter so full/empty come straight from a register.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally at the power-of-two depth; a simultaneous
    // push and pop leaves the occupancy untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage array needs no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue stage: buffers 16-bit instructions, issues operands
// from a 4x8 register file to an external execute unit and retires the
// returned result. Optional feature macro ISSUE_TIMEOUT_EN adds a WAIT
// timeout that abandons an instruction whose result never arrives.
module instr_issue
    import cpu8_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_instr,
    output logic        load_ready,
    output logic [7:0]  a,
    output logic [7:0]  b,
    output logic [2:0]  opcode,
    output logic        issue_valid,
    input  logic        result_valid,
    input  logic [7:0]  result_in,
    input  logic        carry_in,
    output logic        carry_flag,
    output logic        busy,
    output logic [7:0]  retired,
    input  logic [1:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic        timeout_err,
    output logic        spurious_err
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("instr_issue: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    issue_state_t state;
    issue_state_t state_next;

    logic [INSTR_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               writeback;
    logic               timeout_hit;
    instr_t             head;
    logic [1:0]         cur_rd;
    logic [7:0]         regs [4];

    assign head        = decode_instr(fifo_head);
    assign load_ready  = !fifo_full;
    assign issue_valid = (state == ST_ISSUE);
    assign busy        = (state != ST_IDLE) || !fifo_empty;
    assign dbg_data    = regs[dbg_addr];

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (load_valid),
        .pop     (fifo_pop),
        .wr_data (load_instr),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

    // Count result-less WAIT cycles; the abort fires on the last allowed one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != ST_WAIT)
                wait_cnt <= '0;
            else if (!result_valid)
                wait_cnt <= wait_cnt + 1'b1;
            if ((state == ST_WAIT) && !result_valid && timeout_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register for the IDLE -> ISSUE -> WAIT sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state plus the pop and writeback strobes that drive the datapath.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        writeback  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (result_valid) begin
                    writeback  = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands are captured as the head is popped, so they are already
    // stable during ISSUE and hold until the next pop; writeback lands on
    // the WAIT->IDLE edge, ahead of any later operand read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            a            <= '0;
            b            <= '0;
            opcode       <= '0;
            cur_rd       <= '0;
            carry_flag   <= 1'b0;
            retired      <= '0;
            spurious_err <= 1'b0;
        end else begin
            if (fifo_pop) begin
                a      <= regs[head.rd];
                b      <= head.imm_sel ? head.imm : regs[head.rs];
                opcode <= head.opcode;
                cur_rd <= head.rd;
            end
            if (writeback) begin
                regs[cur_rd] <= result_in;
                carry_flag   <= carry_in;
                retired      <= retired + 8'd1;
            end
            if (result_valid && (state != ST_WAIT))
                spurious_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios plus randomized
// traffic, compared cycle by cycle against a queue-based reference model.
// Build with ISSUE_TIMEOUT_EN defined to also exercise the WAIT timeout.
module tb_instr_issue;
    import cpu8_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_instr;
    logic        load_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  opcode;
    logic        issue_valid;
    logic        result_valid;
    logic [7:0]  result_in;
    logic        carry_in;
    logic        carry_flag;
    logic        busy;
    logic [7:0]  retired;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic        timeout_err;
    logic        spurious_err;

    always #5 clk = ~clk;

    instr_issue #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_instr   (load_instr),
        .load_ready   (load_ready),
        .a            (a),
        .b            (b),
        .opcode       (opcode),
        .issue_valid  (issue_valid),
        .result_valid (result_valid),
        .result_in    (result_in),
        .carry_in     (carry_in),
        .carry_flag   (carry_flag),
        .busy         (busy),
        .retired      (retired),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .timeout_err  (timeout_err),
        .spurious_err (spurious_err)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: pending instructions as a queue, the register file
    // as an array, and the instruction in flight as a stage number
    // (0 = nothing in flight, 1 = being issued, 2 = awaiting its result).
    logic [15:0] pendQ[$];
    logic [7:0]  mRegs [4];
    int          phase;
    int          waitCycles;
    logic [1:0]  curRd;
    logic [7:0]  expA;
    logic [7:0]  expB;
    logic [2:0]  expOp;
    logic        mCarry;
    logic [7:0]  mRetired;
    logic        mSpur;
    logic        mTmo;
    int          respondPct;
    int          spurPct;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic isel, input logic [7:0] imm);
        return {op, rd, rs, isel, imm};
    endfunction

    // Execute-unit behaviour used by the responder: {carry, result}.
    function automatic logic [8:0] aluRef(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            OP_ADD:  return {1'b0, x} + {1'b0, y};
            OP_SUB:  return {1'b0, x} - {1'b0, y};
            OP_AND:  return {1'b0, x & y};
            OP_OR:   return {1'b0, x | y};
            OP_XOR:  return {1'b0, x ^ y};
            OP_NOT:  return {1'b0, ~x};
            OP_SHL:  return {x, 1'b0};
            default: return {1'b0, y};
        endcase
    endfunction

    task automatic resetModel();
        pendQ.delete();
        for (int i = 0; i < 4; i++) mRegs[i] = 8'h00;
        phase = 0; waitCycles = 0; curRd = 2'd0;
        expA = 8'h00; expB = 8'h00; expOp = 3'd0;
        mCarry = 1'b0; mRetired = 8'h00; mSpur = 1'b0; mTmo = 1'b0;
    endtask

    task automatic checkAll();
        logic [1:0] da;
        logic       expTmo;
`ifdef ISSUE_TIMEOUT_EN
        expTmo = mTmo;
`else
        expTmo = 1'b0;
`endif
        checkOutput("load_ready", load_ready, pendQ.size() < DEPTH);
        checkOutput("issue_valid", issue_valid, phase == 1);
        checkOutput("busy", busy, (phase != 0) || (pendQ.size() > 0));
        checkOutput("a", a, expA);
        checkOutput("b", b, expB);
        checkOutput("opcode", opcode, expOp);
        checkOutput("carry_flag", carry_flag, mCarry);
        checkOutput("retired", retired, mRetired);
        checkOutput("spurious_err", spurious_err, mSpur);
        checkOutput("timeout_err", timeout_err, expTmo);
        da = 2'($urandom_range(0, 3));
        dbg_addr = da;
        #1;
        checkOutput("dbg_data", dbg_data, mRegs[da]);
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic modelAdvance(input logic lv, input logic [15:0] li, input logic rv,
                                input logic [7:0] rin, input logic cin);
        logic        accept;
        logic [15:0] ins;
        accept = lv && (pendQ.size() < DEPTH);
        if (phase == 0) begin
            if (pendQ.size() > 0) begin
                ins   = pendQ.pop_front();
                curRd = ins[12:11];
                expA  = mRegs[ins[12:11]];
                expB  = ins[8] ? ins[7:0] : mRegs[ins[10:9]];
                expOp = ins[15:13];
                phase = 1;
            end
            if (rv) mSpur = 1'b1;
        end else if (phase == 1) begin
            phase = 2;
            waitCycles = 0;
            if (rv) mSpur = 1'b1;
        end else begin
            if (rv) begin
                mRegs[curRd] = rin;
                mCarry = cin;
                mRetired = mRetired + 8'd1;
                phase = 0;
            end else begin
                waitCycles++;
`ifdef ISSUE_TIMEOUT_EN
                if (waitCycles == TMO) begin
                    mTmo = 1'b1;
                    phase = 0;
                end
`endif
            end
        end
        if (accept) pendQ.push_back(li);
    endtask

    task automatic applyStimulus(input logic lv, input logic [15:0] li, input logic rv,
                                 input logic [7:0] rin, input logic cin);
        @(negedge clk);
        checkAll();
        load_valid   = lv;
        load_instr   = li;
        result_valid = rv;
        result_in    = rin;
        carry_in     = cin;
        modelAdvance(lv, li, rv, rin, cin);
    endtask

    // One cycle with the responder deciding result_valid from the model.
    task automatic autoCycle(input logic lv, input logic [15:0] li, input bit hold);
        logic       rv;
        logic [7:0] rin;
        logic       cin;
        logic [8:0] r;
        rv = 1'b0; rin = 8'h00; cin = 1'b0;
        if (phase == 2) begin
            if (!hold && ($urandom_range(0, 99) < respondPct)) begin
                r   = aluRef(expOp, expA, expB);
                rv  = 1'b1;
                rin = r[7:0];
                cin = r[8];
            end
        end else if ($urandom_range(0, 99) < spurPct) begin
            rv  = 1'b1;
            rin = 8'($urandom);
            cin = 1'($urandom);
        end
        applyStimulus(lv, li, rv, rin, cin);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && !((phase == 0) && (pendQ.size() == 0)); i++)
            autoCycle(1'b0, 16'h0000, 1'b0);
        autoCycle(1'b0, 16'h0000, 1'b0);
        checkOutput("idle_after_drain", busy, 1'b0);
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [7:0] v);
        dbg_addr = addr;
        #1;
        v = dbg_data;
    endtask

    initial begin
        logic [7:0] rv8;
        rst = 1'b1;
        load_valid = 1'b0; load_instr = 16'h0000;
        result_valid = 1'b0; result_in = 8'h00; carry_in = 1'b0;
        dbg_addr = 2'd0;
        respondPct = 100;
        spurPct = 0;
        resetModel();
        #2;
        checkAll();
        checkOutput("reset_load_ready", load_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Two accumulating immediate adds into r0.
        autoCycle(1'b1, mk(OP_ADD, 2'd0, 2'd0, 1'b1, 8'd5), 1'b0);
        autoCycle(1'b1, mk(OP_ADD, 2'd0, 2'd0, 1'b1, 8'd3), 1'b0);
        drain();
        readReg(2'd0, rv8);
        checkOutput("add_r0", rv8, 8'h08);
        checkOutput("add_retired", retired, 8'd2);
        checkOutput("add_carry", carry_flag, 1'b0);

        // Dependent AND reads the freshly written r1.
        autoCycle(1'b1, mk(OP_ADD, 2'd1, 2'd0, 1'b1, 8'hCC), 1'b0);
        autoCycle(1'b1, mk(OP_AND, 2'd1, 2'd0, 1'b1, 8'hAA), 1'b0);
        drain();
        readReg(2'd1, rv8);
        checkOutput("and_r1", rv8, 8'h88);

        // Result pulse while idle.
        applyStimulus(1'b0, 16'h0000, 1'b1, 8'h77, 1'b1);
        autoCycle(1'b0, 16'h0000, 1'b0);
        checkOutput("spurious_set", spurious_err, 1'b1);
        readReg(2'd0, rv8);
        checkOutput("spurious_r0_kept", rv8, 8'h08);

        // Fill the buffer behind a stalled instruction.
        autoCycle(1'b1, mk(OP_PASS, 2'd2, 2'd0, 1'b1, 8'h10), 1'b1);
        for (int i = 0; i < 10 && phase != 2; i++) autoCycle(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 6; k++) autoCycle(1'b1, mk(OP_ADD, 2'd2, 2'd0, 1'b1, 8'(k + 1)), 1'b1);
        checkOutput("full_ready", load_ready, 1'b0);
        checkOutput("full_busy", busy, 1'b1);
        drain();
        readReg(2'd2, rv8);
        checkOutput("fill_r2", rv8, 8'h1A);

`ifdef ISSUE_TIMEOUT_EN
        // Withheld result times out; the next instruction still issues.
        autoCycle(1'b1, mk(OP_ADD, 2'd3, 2'd0, 1'b1, 8'd9), 1'b1);
        autoCycle(1'b1, mk(OP_ADD, 2'd3, 2'd0, 1'b1, 8'd4), 1'b1);
        for (int i = 0; i < TMO + 4; i++) autoCycle(1'b0, 16'h0000, 1'b1);
        checkOutput("timeout_set", timeout_err, 1'b1);
        drain();
        readReg(2'd3, rv8);
        checkOutput("timeout_r3", rv8, 8'h04);
`endif

        // Asynchronous reset while an instruction waits for its result.
        autoCycle(1'b1, mk(OP_ADD, 2'd0, 2'd0, 1'b1, 8'h40), 1'b1);
        for (int i = 0; i < 10 && phase != 2; i++) autoCycle(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1'b1);
        result_valid = 1'b1; result_in = 8'h55; carry_in = 1'b1;
        rst = 1'b1;
        #1;
        resetModel();
        checkAll();
        checkOutput("rst_busy", busy, 1'b0);
        readReg(2'd0, rv8);
        checkOutput("rst_r0", rv8, 8'h00);
        result_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic.
        respondPct = 60;
        spurPct = 2;
        for (int i = 0; i < 500; i++)
            autoCycle(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        respondPct = 100;
        spurPct = 0;
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
